// File: rtl/round_key_sched.sv
// AES-128 round-key scheduler: expands one cipher key into 11 stored round keys.
// Ports: clk, rst, key_in/key_valid/key_ready, rd_addr/rd_data, busy, keys_valid.

module key_gen (
  input  logic [3:0]   rc,
  input  logic [127:0] key,
  output logic [127:0] next
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  endfunction

  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, tmp;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    rcon = 8'h00;
    case (rc)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0  = key[127:96];
  assign w1  = key[95:64];
  assign w2  = key[63:32];
  assign w3  = key[31:0];
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]),
                sbox(rot[15:8]),  sbox(rot[7:0])};
  assign tmp = sub ^ {rcon, 24'h0};
  assign n0  = w0 ^ tmp;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign next = {n0, n1, n2, n3};

endmodule

module round_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_data,
  output logic         busy,
  output logic         keys_valid
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  state_t       state;
  logic [3:0]   rc;
  logic [127:0] slot [0:10];
  logic [127:0] kg_in;
  logic [127:0] kg_out;

  assign kg_in = slot[rc];

  key_gen u_kg (
    .rc   (rc),
    .key  (kg_in),
    .next (kg_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rc         <= 4'd0;
      rd_data    <= '0;
      keys_valid <= 1'b0;
      busy       <= 1'b0;
      key_ready  <= 1'b1;
      for (int i = 0; i < 11; i++) slot[i] <= '0;
    end else begin
      // Read sees the slot contents before this edge's write.
      rd_data <= (rd_addr < 4'd11) ? slot[rd_addr] : '0;
      case (state)
        IDLE, DONE: begin
          if (key_valid) begin
            slot[0]    <= key_in;
            rc         <= 4'd0;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            key_ready  <= 1'b0;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          slot[rc + 4'd1] <= kg_out;
          if (rc == 4'd9) begin
            rc         <= 4'd0;
            keys_valid <= 1'b1;
            busy       <= 1'b0;
            key_ready  <= 1'b1;
            state      <= DONE;
          end else begin
            rc <= rc + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
